// File: rtl/dec_3_pkg.sv
// Shared definitions for the dec_3 decoder layer: default fixed-point format
// and the controller state encoding.
package dec_3_pkg;

  localparam int unsigned DefBitsize  = 16;
  localparam int unsigned DefFracBits = 10;
  localparam int unsigned DefNIn      = 6;
  localparam int unsigned IdxWidth    = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StOut  = 2'd2
  } state_e;

endpackage

// File: rtl/dec_3_mac.sv
// Combinational fixed-point multiply-accumulate: sum = acc + ((a * b) >>> FracBits),
// with the product truncated and the sum wrapped to Width bits.
module dec_3_mac #(
  parameter int unsigned Width    = 16,
  parameter int unsigned FracBits = 10
) (
  input  logic [Width-1:0] acc_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o
);

  logic signed [2*Width-1:0] a_ext;
  logic signed [2*Width-1:0] b_ext;
  logic signed [2*Width-1:0] prod;
  logic        [Width-1:0]   prod_scaled;

  assign a_ext = {{Width{a_i[Width-1]}}, a_i};
  assign b_ext = {{Width{b_i[Width-1]}}, b_i};
  assign prod  = a_ext * b_ext;

  // Arithmetic shift floors toward minus infinity; no rounding or saturation.
  assign prod_scaled = Width'(prod >>> FracBits);
  assign sum_o       = acc_i + prod_scaled;

endmodule

// File: rtl/dec_3.sv
// Sequential 1x6 decoder layer: y = b + sum(w[i]*x[i]) using one shared MAC over
// six cycles, with valid/ready handshakes on input and output.
module dec_3
  import dec_3_pkg::*;
#(
  parameter int unsigned BITSIZE   = DefBitsize,
  parameter int unsigned FRAC_BITS = DefFracBits,
  parameter int unsigned N_IN      = DefNIn
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BITSIZE*N_IN-1:0] x,
  input  logic [BITSIZE*N_IN-1:0] w,
  input  logic [BITSIZE-1:0]      b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BITSIZE-1:0]      y
);

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(N_IN - 1);

  state_e                         state_q, state_d;
  logic [IdxWidth-1:0]            idx_q, idx_d;
  logic [N_IN-1:0][BITSIZE-1:0]   x_q, x_d;
  logic [N_IN-1:0][BITSIZE-1:0]   w_q, w_d;
  logic [BITSIZE-1:0]             acc_q, acc_d;
  logic [BITSIZE-1:0]             y_q, y_d;
  logic [BITSIZE-1:0]             mac_sum;

  dec_3_mac #(
    .Width    (BITSIZE),
    .FracBits (FRAC_BITS)
  ) u_mac (
    .acc_i (acc_q),
    .a_i   (w_q[idx_q]),
    .b_i   (x_q[idx_q]),
    .sum_o (mac_sum)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    w_d     = w_q;
    acc_d   = acc_q;
    y_d     = y_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = x;
          w_d     = w;
          acc_d   = b;
          idx_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = mac_sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          y_d     = mac_sum;
          idx_d   = '0;
          state_d = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      x_q     <= '0;
      w_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

  // Handshake flags come from registered state only.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign y         = y_q;

endmodule

// File: tb/tb_dec_3.sv
// Self-checking bench for dec_3: directed and random transactions against a
// floor-division reference model, with stalls, mid-operation reset and back-to-back.
module tb_dec_3;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] x;
  logic [95:0] w;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;

  int tests;
  int fails;
  int cyc;

  dec_3 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w         (w),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  // Real-valued Q5.10 arithmetic: each product floored to 1/1024, everything mod 2^16.
  function automatic logic [15:0] ref_y(input logic [95:0] xv, input logic [95:0] wv,
                                        input logic [15:0] bv);
    longint      acc;
    longint      xi;
    longint      wi;
    logic [63:0] t;
    acc = longint'($signed(bv));
    for (int i = 0; i < 6; i++) begin
      xi  = longint'($signed(xv[16*i +: 16]));
      wi  = longint'($signed(wv[16*i +: 16]));
      acc = acc + floor_div(xi * wi, 1024);
    end
    t = acc;
    return t[15:0];
  endfunction

  function automatic logic [95:0] rand96();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic logic [95:0] fill(input logic [15:0] v);
    return {6{v}};
  endfunction

  task automatic do_txn(input string tag, input logic [95:0] xv, input logic [95:0] wv,
                        input logic [15:0] bv, input int stall);
    logic [15:0] exp_y;
    int          lat;
    exp_y     = ref_y(xv, wv, bv);
    x         = xv;
    w         = wv;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    check({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    // Inputs may change freely once accepted; with stalls keep offering new data.
    in_valid = (stall > 0);
    x        = rand96();
    w        = rand96();
    b        = 16'($urandom);
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":latency"}, 32'(lat), 32'd6);
    check({tag, ":y"}, 32'(y), 32'(exp_y));
    check({tag, ":in_ready_busy"}, 32'(in_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      x = rand96();
      b = 16'($urandom);
      @(posedge clk); #1;
      check({tag, ":stall_y"}, 32'(y), 32'(exp_y));
      check({tag, ":stall_vld"}, 32'(out_valid), 32'd1);
      check({tag, ":stall_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ":post_vld"}, 32'(out_valid), 32'd0);
    check({tag, ":post_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [95:0] xs [4];
    logic [95:0] ws [4];
    logic [15:0] bs [4];
    logic [95:0] xv;
    logic [95:0] wv;
    int          cnt;
    int          prev_cyc;

    tests     = 0;
    fails     = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    w         = '0;
    b         = '0;
    #1;
    check("rst_y", 32'(y), 32'd0);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);
    #20;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    do_txn("basic", fill(16'h0400), fill(16'h0200), 16'h0100, 0);
    check("basic_const", 32'(ref_y(fill(16'h0400), fill(16'h0200), 16'h0100)), 32'h0D00);

    do_txn("neg", {80'h0, 16'hFC00}, {80'h0, 16'h0800}, 16'h0000, 0);
    do_txn("floor_neg", {80'h0, 16'hFFFF}, {80'h0, 16'h0001}, 16'h0000, 0);
    do_txn("floor_pos", {80'h0, 16'h0001}, {80'h0, 16'h0001}, 16'h1234, 0);
    do_txn("wrap", fill(16'h7C00), fill(16'h0400), 16'h0000, 0);
    do_txn("backpressure", rand96(), rand96(), 16'($urandom), 10);
    do_txn("after_bp", rand96(), rand96(), 16'($urandom), 0);

    // Reset in the middle of MAC (idx == 3) discards the partial result.
    x        = fill(16'h0400);
    w        = fill(16'h0400);
    b        = 16'h0100;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("midrst_y", 32'(y), 32'd0);
    check("midrst_vld", 32'(out_valid), 32'd0);
    check("midrst_rdy", 32'(in_ready), 32'd1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    do_txn("post_rst", fill(16'h0C00), {80'h0, 16'h0400}, 16'h0000, 0);

    for (int r = 0; r < 6; r++) begin
      do_txn("random", rand96(), rand96(), 16'($urandom), int'($urandom_range(0, 3)));
    end

    // Back-to-back with in_valid and out_ready held high.
    for (int t = 0; t < 4; t++) begin
      xs[t] = rand96();
      ws[t] = rand96();
      bs[t] = 16'($urandom);
    end
    x         = xs[0];
    w         = ws[0];
    b         = bs[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    prev_cyc  = 0;
    for (int t = 0; t < 3; t++) begin
      cnt = 0;
      while (in_ready && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      xv = xs[t + 1];
      wv = ws[t + 1];
      x  = xv;
      w  = wv;
      b  = bs[t + 1];
      if (t == 2) in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      check("b2b_y", 32'(y), 32'(ref_y(xs[t], ws[t], bs[t])));
      if (t > 0) check("b2b_period", 32'(cyc - prev_cyc), 32'd8);
      prev_cyc = cyc;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("b2b_end_rdy", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
